uart_rx_frame_ctrl: RTL

Frame controller that sits directly behind `uart_rx` and turns its byte stream (`data_out`/`data_rdy`) into validated register-write bursts. It parses framed packets (sync, address, length, payload, checksum), buffers the payload, and supervises inter-byte timeout. Only after the checksum passes does it sequence one write per cycle onto a simple register bus.

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 41 ++++
 rtl/uart_rx_frame_ctrl_if.sv | 28 ++
 rtl/uart_rx_frame_ctrl_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_frame_defs: shared definitions for the UART frame controller.
//   state_t      FSM state encoding
//   err_t        err_code values reported with frame_err
//   wr_req_t     one register-bus write (strobe, address, data)
//   SYNC_DEFAULT default frame start byte
//   bit_cyc / timeout_cyc  derive cycle counts from clock, baud and bit-times
package uart_frame_defs;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_DATA,
      ST_CHK,
      ST_DRAIN
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_CHK     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

   typedef struct packed {
      logic       en;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_req_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   function automatic int bit_cyc(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int timeout_cyc(input int bits, input int cyc_per_bit);
      return bits * cyc_per_bit;
   endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: byte input from uart_rx plus the register-write
// bus and frame status outputs of the frame controller.
//   rx_data/rx_rdy    byte and one-cycle strobe from uart_rx
//   wr_en/addr/data   register write port, one write per cycle
//   frame_ok/err      one-cycle frame result pulses, err_code with frame_err
//   busy              controller is inside a frame
// modport slave is the frame controller, master is the upstream/observer.
interface uart_rx_frame_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   modport master (
      output rx_data, rx_rdy,
      input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
   );

   modport slave (
      input  rx_data, rx_rdy,
      output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
   );
endinterface

// File: rtl/uart_rx_frame_ctrl_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload buffer.
//   clk      system clock
//   we/wa/wd write port, used while collecting payload
//   ra/rd    combinational read port, indexed by the drain counter
// Contents are not reset; every entry read is written earlier in the frame.
module uart_frame_buf #(
   parameter int MAX_LEN = 16,
   parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [7:0]    wd,
   input  logic [AW-1:0] ra,
   output logic [7:0]    rd
);
   logic [7:0] mem [MAX_LEN];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC, ADDR, LEN, D0..D(LEN-1), CHK frames from
// the uart_rx byte stream, buffers the payload and, once the 8-bit wrapping
// checksum matches, issues one register write per cycle at ADDR+i.
//   clk, rst  system clock, synchronous active-high reset (silent abort)
//   bus       uart_rx_frame_ctrl_if.slave: rx_data/rx_rdy in; wr_en,
//             wr_addr, wr_data, frame_ok, frame_err, err_code, busy out
// All outputs are registered from the next-state logic, so a write decided
// on the CHK byte edge is already on the bus the following cycle.
module uart_rx_frame_ctrl
   import uart_frame_defs::*;
#(
   parameter int         CLK_HZ       = 125000000,
   parameter int         BAUD         = 115200,
   parameter int         TIMEOUT_BITS = 20,
   parameter logic [7:0] SYNC         = SYNC_DEFAULT,
   parameter int         MAX_LEN      = 16
) (
   input logic                 clk,
   input logic                 rst,
   uart_rx_frame_ctrl_if.slave bus
);
   localparam int BIT_CYC     = bit_cyc(CLK_HZ, BAUD);
   localparam int TIMEOUT_CYC = timeout_cyc(TIMEOUT_BITS, BIT_CYC);
   localparam int TW          = $clog2(TIMEOUT_CYC + 1);
   localparam int IW          = $clog2(MAX_LEN + 1);
   localparam int AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t        state_q, state_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    sum_q, sum_d;
   logic [IW-1:0] len_q, len_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;

   wr_req_t wr_q, wr_d;
   logic    ok_q, ok_d;
   logic    err_q, err_d;
   err_t    code_q, code_d;
   logic    busy_q, busy_d;

   logic       in_frame, tmo_hit, rx_acc;
   logic [7:0] rd_data;

   uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
      .clk (clk),
      .we  (state_q == ST_DATA && rx_acc),
      .wa  (idx_q[AW-1:0]),
      .wd  (bus.rx_data),
      .ra  (idx_q[AW-1:0]),
      .rd  (rd_data)
   );

   // tmo_q holds k-1 on the k-th cycle after the last accepted byte, so the
   // timeout is decided on cycle TIMEOUT_CYC after that byte and frame_err is
   // visible one cycle later (TIMEOUT_CYC+1 after the strobe). A byte on the
   // deciding cycle loses to the timeout and is dropped.
   assign in_frame = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
   assign tmo_hit  = in_frame && (tmo_q == TW'(TIMEOUT_CYC - 1));
   assign rx_acc   = bus.rx_rdy && !tmo_hit && (state_q != ST_DRAIN);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      len_d   = len_q;
      idx_d   = idx_q;
      tmo_d   = in_frame ? tmo_q + TW'(1) : '0;
      wr_d    = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;

      if (rx_acc) tmo_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (rx_acc && bus.rx_data == SYNC) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (rx_acc) begin
               addr_d  = bus.rx_data;
               sum_d   = bus.rx_data;
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_acc) begin
               if (bus.rx_data == 8'd0 || int'(bus.rx_data) > MAX_LEN) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = ST_IDLE;
               end else begin
                  len_d   = bus.rx_data[IW-1:0];
                  sum_d   = sum_q + bus.rx_data;
                  idx_d   = '0;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rx_acc) begin
               sum_d = sum_q + bus.rx_data;
               if (idx_q == len_q - IW'(1)) begin
                  idx_d   = '0;   // CHK then reads entry 0 for the first write
                  state_d = ST_CHK;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_CHK: begin
            if (rx_acc) begin
               if (bus.rx_data == sum_q) begin
                  // First write goes out on the cycle right after the CHK byte.
                  wr_d    = '{en: 1'b1, addr: addr_q, data: rd_data};
                  ok_d    = (len_q == IW'(1));
                  idx_d   = IW'(1);
                  state_d = ST_DRAIN;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_CHK;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            // idx_q is the next write; idx_q == len_q is the cycle of the last
            // write on the bus, after which busy drops.
            if (idx_q == len_q) begin
               state_d = ST_IDLE;
            end else begin
               wr_d  = '{en: 1'b1, addr: addr_q + 8'(idx_q), data: rd_data};
               ok_d  = (idx_q == len_q - IW'(1));
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (tmo_hit) begin
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
         state_d = ST_IDLE;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         sum_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         tmo_q   <= '0;
         wr_q    <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         wr_q    <= wr_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.wr_en     = wr_q.en;
   assign bus.wr_addr   = wr_q.addr;
   assign bus.wr_data   = wr_q.data;
   assign bus.frame_ok  = ok_q;
   assign bus.frame_err = err_q;
   assign bus.err_code  = code_q;
   assign bus.busy      = busy_q;
endmodule
